// File: rtl/bolge_is_denetleyici.sv
// Region-detector sequencer: hands 16-bit messages to an external detector, samples its 2-bit region
// after BEKLEME settle cycles, returns message+region and keeps saturating per-region hit counters.
// Optional odd-parity rejection of incoming messages is enabled by defining BOLGE_PARITE_EN.
module bolge_is_denetleyici #(
  parameter int BEKLEME = 1,
  parameter int SAYAC_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 giris_gecerli,
  output logic                 giris_hazir,
  input  logic [15:0]          giris_mesaj,
  output logic [15:0]          mesaj,
  input  logic [1:0]           bolge,
  output logic                 cikis_gecerli,
  input  logic                 cikis_hazir,
  output logic [15:0]          cikis_mesaj,
  output logic [1:0]           cikis_bolge,
  input  logic                 sayac_sil,
  output logic [4*SAYAC_W-1:0] sayaclar,
  output logic [SAYAC_W-1:0]   hata_sayac,
  output logic                 mesgul
);

  typedef enum logic [1:0] {
    BOS   = 2'd0,
    BEKLE = 2'd1,
    CIKIS = 2'd2
  } durum_t;

  localparam logic [3:0] BEKLEME_YUK = 4'(BEKLEME);

  durum_t             durum_r, durum_s;
  logic [3:0]         bekle_r, bekle_s;
  logic               kabul_s;
  logic               ornek_s;
  logic [SAYAC_W-1:0] sayac_r [4];

  function automatic logic [SAYAC_W-1:0] doygun_artir(input logic [SAYAC_W-1:0] v);
    if (v == {SAYAC_W{1'b1}}) begin
      return v;
    end else begin
      return v + SAYAC_W'(1'b1);
    end
  endfunction

`ifdef BOLGE_PARITE_EN
  logic red_s;

  function automatic logic tek_parite(input logic [15:0] v);
    return ^v;
  endfunction
`endif

  assign giris_hazir = (durum_r == BOS);

  // Next-state and per-edge strobes: accept in BOS, sample on the last settle cycle.
  always_comb begin
    durum_s = durum_r;
    bekle_s = bekle_r;
    kabul_s = 1'b0;
    ornek_s = 1'b0;
`ifdef BOLGE_PARITE_EN
    red_s   = 1'b0;
`endif
    case (durum_r)
      BOS: begin
        if (giris_gecerli) begin
`ifdef BOLGE_PARITE_EN
          if (tek_parite(giris_mesaj)) begin
            red_s = 1'b1;
          end else begin
            kabul_s = 1'b1;
            durum_s = BEKLE;
            bekle_s = BEKLEME_YUK;
          end
`else
          kabul_s = 1'b1;
          durum_s = BEKLE;
          bekle_s = BEKLEME_YUK;
`endif
        end else begin
          durum_s = BOS;
        end
      end
      BEKLE: begin
        if (bekle_r == 4'd1) begin
          ornek_s = 1'b1;
          durum_s = CIKIS;
        end else begin
          bekle_s = bekle_r - 4'd1;
        end
      end
      CIKIS: begin
        if (cikis_hazir) begin
          durum_s = BOS;
        end else begin
          durum_s = CIKIS;
        end
      end
      default: begin
        durum_s = BOS;
        bekle_s = 4'd0;
      end
    endcase
  end

  // State register, settle counter and the status flags that mirror the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      durum_r       <= BOS;
      bekle_r       <= 4'd0;
      cikis_gecerli <= 1'b0;
      mesgul        <= 1'b0;
    end else begin
      durum_r       <= durum_s;
      bekle_r       <= bekle_s;
      cikis_gecerli <= (durum_s == CIKIS);
      mesgul        <= (durum_s != BOS);
    end
  end

  // Message and result registers; mesaj keeps the last accepted message while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mesaj       <= 16'h0000;
      cikis_mesaj <= 16'h0000;
      cikis_bolge <= 2'd0;
    end else begin
      if (kabul_s) begin
        mesaj       <= giris_mesaj;
        cikis_mesaj <= giris_mesaj;
      end
      if (ornek_s) begin
        cikis_bolge <= bolge;
      end
    end
  end

  // Saturating region hit counters; a clear on the sample edge drops that increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < 4; r++) begin
        sayac_r[r] <= {SAYAC_W{1'b0}};
      end
    end else if (sayac_sil) begin
      for (int r = 0; r < 4; r++) begin
        sayac_r[r] <= {SAYAC_W{1'b0}};
      end
    end else if (ornek_s) begin
      sayac_r[bolge] <= doygun_artir(sayac_r[bolge]);
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_sayac_cikis
    assign sayaclar[g*SAYAC_W +: SAYAC_W] = sayac_r[g];
  end

`ifdef BOLGE_PARITE_EN
  // Parity-error counter, cleared together with the region counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hata_sayac <= {SAYAC_W{1'b0}};
    end else if (sayac_sil) begin
      hata_sayac <= {SAYAC_W{1'b0}};
    end else if (red_s) begin
      hata_sayac <= doygun_artir(hata_sayac);
    end
  end
`else
  assign hata_sayac = {SAYAC_W{1'b0}};
`endif

endmodule
